pipeline_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, and flush-to-bubble. It replaces the fixed per-stage latch registers between IF/ID, ID/EX, EX/MEM and MEM/WB. Control and data fields are carried separately so that a flush always zeroes control bits, while data bits are zeroed only when configured to be. Two saturating performance counters report bubbles and flushed entries.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/sat_counter.sv | 40 ++++
 rtl/pipeline_stage_skid.sv | 219 +++++++++++++++++++++
 tb/tb_pipeline_stage_skid.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the pipeline stage register with skid buffer.
//   stage_state_t : occupancy state of one stage (EMPTY / ONE / TWO)
//   DATA_W_DEF    : default payload width (register values, immediate, address)
//   CTRL_W_DEF    : default control field width (alu_op, mem_op, reg_write, ...)
//   CNT_W_DEF     : default performance counter width
//   occupancy()   : number of valid entries held in a given state (0..2)
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int DATA_W_DEF = 64;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    function automatic logic [1:0] occupancy(input stage_state_t s);
        logic [1:0] n;
        case (s)
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter. On every falling clock edge where enable is high the
// count advances by inc_amount and sticks at 2^W-1 instead of wrapping.
// Cleared only by the asynchronous active-high reset.
//
// Ports:
//   clk        in   stage clock (state updates on the falling edge)
//   reset      in   asynchronous, active-high clear
//   enable     in   add inc_amount on this edge
//   inc_amount in   AMT_W-bit increment
//   count      out  W-bit saturating count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W     = 16,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [AMT_W-1:0] inc_amount,
    output logic [W-1:0]     count
);

    // One extra bit catches the carry out of the W-bit range; since the
    // increment is narrower than the counter, a single carry bit suffices.
    logic [W:0] sum;

    assign sum = {1'b0, count} + {{(W + 1 - AMT_W){1'b0}}, inc_amount};

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= sum[W] ? {W{1'b1}} : sum[W-1:0];
        end
    end

endmodule

// File: rtl/pipeline_stage_skid.sv
// ---------------------------------------------------------------------------
// pipeline_stage_skid
//
// Pipeline stage register with a valid/ready handshake, a two-entry skid
// buffer and flush-to-bubble. Sits between IF/ID, ID/EX, EX/MEM and MEM/WB.
// Control and data travel in separate fields: a flush always zeroes control,
// data is zeroed only when CLEAR_DATA = 1. All state updates on the falling
// clock edge.
//
// Ports:
//   clk          in   stage clock (falling-edge active)
//   reset        in   asynchronous, active-high; clears all state at once
//   flush        in   discard held and incoming entries on this edge
//   in_valid     in   upstream offers an entry
//   in_ready     out  stage can accept (registered: high unless skid is full)
//   in_ctrl      in   incoming control field
//   in_data      in   incoming data field
//   out_valid    out  main entry valid
//   out_ready    in   downstream accepts
//   out_ctrl     out  main entry control field
//   out_data     out  main entry data field
//   bubble_cnt   out  saturating count of edges with out_ready & !out_valid
//   flushed_cnt  out  saturating count of valid entries discarded by flush
// ---------------------------------------------------------------------------
module pipeline_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flushed_cnt
);

    stage_state_t      state;
    stage_state_t      state_next;

    logic              main_valid;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;

    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic              load_main_in;
    logic              load_skid_in;
    logic              move_skid;

    logic              bubble_en;
    logic [1:0]        flushed_amount;

    // Valid bits are a pure function of the occupancy state, so they can
    // never disagree with it.
    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == TWO);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // An incoming entry lands in main when main is free or is draining on
    // this edge; otherwise it lands in skid. In TWO in_ready is low, so
    // in_fire cannot occur there.
    assign load_main_in = in_fire & (~main_valid | out_fire);
    assign load_skid_in = in_fire & main_valid & ~out_fire;
    assign move_skid    = skid_valid & out_fire;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic; flush overrides every transition
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next = TWO;
                    end else if (!in_fire && out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic; in_ready comes straight from the state register so there
    // is no combinational path from out_ready to in_ready.
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid = main_valid;
        in_ready  = ~skid_valid;
        out_ctrl  = main_ctrl;
        out_data  = main_data;
    end

    // -----------------------------------------------------------------------
    // Control fields: always zeroed by flush
    // -----------------------------------------------------------------------
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
            end else if (move_skid) begin
                main_ctrl <= skid_ctrl;
            end

            if (load_skid_in) begin
                skid_ctrl <= in_ctrl;
            end else if (move_skid) begin
                skid_ctrl <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data fields: zeroed by flush only when CLEAR_DATA is set, otherwise
    // they keep their last value (their valid bits are already cleared).
    // -----------------------------------------------------------------------
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            if (CLEAR_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (move_skid) begin
                main_data <= skid_data;
            end

            if (load_skid_in) begin
                skid_data <= in_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
    assign bubble_en = out_ready & ~out_valid;

    // Entries lost on a flush edge: everything held plus an accepted offer.
    assign flushed_amount = occupancy(state) + {1'b0, in_fire};

    sat_counter #(
        .W     (CNT_W),
        .AMT_W (2)
    ) u_bubble_cnt (
        .clk        (clk),
        .reset      (reset),
        .enable     (bubble_en),
        .inc_amount (2'd1),
        .count      (bubble_cnt)
    );

    sat_counter #(
        .W     (CNT_W),
        .AMT_W (2)
    ) u_flushed_cnt (
        .clk        (clk),
        .reset      (reset),
        .enable     (flush),
        .inc_amount (flushed_amount),
        .count      (flushed_cnt)
    );

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid. Two instances share all inputs:
//   dut_a: CLEAR_DATA = 0, CNT_W = 16
//   dut_b: CLEAR_DATA = 1, CNT_W = 4 (counter saturation at 15)
// A queue holds the entries the stage should be presenting, in order.
module tb_pipeline_stage_skid;

    localparam int DW = 64;
    localparam int CW = 12;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl   = '0;
    logic [DW-1:0] in_data   = '0;

    logic          in_ready_a, out_valid_a;
    logic [CW-1:0] out_ctrl_a;
    logic [DW-1:0] out_data_a;
    logic [15:0]   bubble_a, flushed_a;

    logic          in_ready_b, out_valid_b;
    logic [CW-1:0] out_ctrl_b;
    logic [DW-1:0] out_data_b;
    logic [3:0]    bubble_b, flushed_b;

    always #5 clk = ~clk;

    pipeline_stage_skid #(
        .DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_ctrl(out_ctrl_a), .out_data(out_data_a),
        .bubble_cnt(bubble_a), .flushed_cnt(flushed_a)
    );

    pipeline_stage_skid #(
        .DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_ctrl(out_ctrl_b), .out_data(out_data_b),
        .bubble_cnt(bubble_b), .flushed_cnt(flushed_b)
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    typedef struct {
        logic          iv;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          exp_rdy;   // in_ready after the edge
        logic          exp_vld;   // out_valid after the edge
    } vec_t;

    entry_t sb[$];
    int     bub_exp = 0;
    int     fl_exp  = 0;
    int     checks  = 0;
    int     errors  = 0;
    vec_t   vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sat(input int v, input int maxv);
        return (v > maxv) ? 64'(maxv) : 64'(v);
    endfunction

    function automatic logic [DW-1:0] mkdata(input logic [CW-1:0] c);
        return {4'hD, 48'h0000_5A5A_0000, c};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [CW-1:0] c, input logic ordy,
                                input logic fl, input logic rdy, input logic vld);
        vec_t v;
        v.iv = iv; v.c = c; v.ordy = ordy; v.fl = fl; v.exp_rdy = rdy; v.exp_vld = vld;
        return v;
    endfunction

    // One stage cycle: drive, compare presented entry before the edge,
    // update the model, compare counters after the edge.
    task automatic cycle(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        int     occ;
        logic   fire_in;
        entry_t e;
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
        #1;
        occ = sb.size();
        check("in_ready", 64'(in_ready_a), 64'(occ < 2));
        check("out_valid", 64'(out_valid_a), 64'(occ > 0));
        check("b_out_valid", 64'(out_valid_b), 64'(occ > 0));
        if (occ > 0) begin
            check("out_ctrl", 64'(out_ctrl_a), 64'(sb[0].ctrl));
            check("out_data", out_data_a, sb[0].data);
            check("b_out_ctrl", 64'(out_ctrl_b), 64'(sb[0].ctrl));
        end
        fire_in = iv && (occ < 2);
        if (ordy && occ == 0) bub_exp++;
        if (fl) begin
            fl_exp += occ + int'(fire_in);
            sb.delete();
        end else begin
            if (ordy && occ > 0) void'(sb.pop_front());
            if (fire_in) begin
                e.ctrl = c; e.data = d;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        #1;
        check("bubble_cnt", 64'(bubble_a), sat(bub_exp, 65535));
        check("flushed_cnt", 64'(flushed_a), sat(fl_exp, 65535));
        check("b_bubble_cnt", 64'(bubble_b), sat(bub_exp, 15));
        check("b_flushed_cnt", 64'(flushed_b), sat(fl_exp, 15));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid_a), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
        check({tag, "_out_ctrl"}, 64'(out_ctrl_a), 64'd0);
        check({tag, "_out_data"}, out_data_a, 64'd0);
        check({tag, "_bubble"}, 64'(bubble_a), 64'd0);
        check({tag, "_flushed"}, 64'(flushed_a), 64'd0);
        check({tag, "_b_out_valid"}, 64'(out_valid_b), 64'd0);
        check({tag, "_b_bubble"}, 64'(bubble_b), 64'd0);
        check({tag, "_b_flushed"}, 64'(flushed_b), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] d21, d31;
        int            fl_before;

        // Stream 0x001..0x005 at full throughput, then drain.
        vecs[0]  = mk(1'b1, 12'h001, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[1]  = mk(1'b1, 12'h002, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[2]  = mk(1'b1, 12'h003, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[3]  = mk(1'b1, 12'h004, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[4]  = mk(1'b1, 12'h005, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[5]  = mk(1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);
        // Stall/skid: A, B, C with out_ready low for three cycles.
        vecs[6]  = mk(1'b1, 12'h00A, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[7]  = mk(1'b1, 12'h00B, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 12'h00C, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(1'b1, 12'h00C, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b1, 12'h00C, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(1'b1, 12'h00C, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[12] = mk(1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset state
        #1 reset = 1'b1;
        #1 reset_checks("reset");
        @(negedge clk);
        #1 reset = 1'b0;

        // Table-driven stream and stall sequences
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].iv, vecs[i].c, mkdata(vecs[i].c), vecs[i].ordy, vecs[i].fl);
            check($sformatf("tbl%0d_in_ready", i), 64'(in_ready_a), 64'(vecs[i].exp_rdy));
            check($sformatf("tbl%0d_out_valid", i), 64'(out_valid_a), 64'(vecs[i].exp_vld));
            if (i == 5) check("stream_bubble_one", 64'(bubble_a), 64'd1);
        end

        // Flush in TWO while an offer is blocked
        d21 = mkdata(12'h021);
        cycle(1'b1, 12'h021, d21, 1'b0, 1'b0);
        cycle(1'b1, 12'h022, mkdata(12'h022), 1'b0, 1'b0);
        check("two_in_ready_low", 64'(in_ready_a), 64'd0);
        fl_before = fl_exp;
        cycle(1'b1, 12'h023, mkdata(12'h023), 1'b0, 1'b1);
        check("flush_two_valid", 64'(out_valid_a), 64'd0);
        check("flush_two_ctrl", 64'(out_ctrl_a), 64'd0);
        check("flush_two_data_held", out_data_a, d21);
        check("flush_two_b_ctrl", 64'(out_ctrl_b), 64'd0);
        check("flush_two_b_data_zero", out_data_b, 64'd0);
        check("flush_two_cnt", 64'(flushed_a), 64'(fl_before + 2));

        // Flush in ONE with an accepted offer on the same edge
        d31 = mkdata(12'h031);
        cycle(1'b1, 12'h031, d31, 1'b0, 1'b0);
        fl_before = fl_exp;
        cycle(1'b1, 12'h032, mkdata(12'h032), 1'b0, 1'b1);
        check("flush_one_valid", 64'(out_valid_a), 64'd0);
        check("flush_one_ctrl", 64'(out_ctrl_a), 64'd0);
        check("flush_one_data_held", out_data_a, d31);
        check("flush_one_cnt", 64'(flushed_a), 64'(fl_before + 2));
        cycle(1'b0, 12'h000, 64'd0, 1'b1, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 80; i++) begin
            logic [CW-1:0] rc;
            rc = CW'($urandom);
            cycle(1'($urandom_range(0, 1)), rc, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0));
        end
        cycle(1'b0, 12'h000, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 12'h000, 64'd0, 1'b1, 1'b0);

        // Bubble counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) cycle(1'b0, 12'h000, 64'd0, 1'b1, 1'b0);
        check("b_bubble_saturated", 64'(bubble_b), 64'd15);

        // Asynchronous reset mid-stall (state TWO), between edges
        cycle(1'b1, 12'h041, mkdata(12'h041), 1'b0, 1'b0);
        cycle(1'b1, 12'h042, mkdata(12'h042), 1'b0, 1'b0);
        check("pre_reset_two", 64'(in_ready_a), 64'd0);
        #2 reset = 1'b1;
        #1 reset_checks("async_reset");
        sb.delete();
        bub_exp = 0;
        fl_exp  = 0;
        @(negedge clk);
        #1 reset = 1'b0;

        // Recovery after reset
        cycle(1'b1, 12'h051, mkdata(12'h051), 1'b1, 1'b0);
        cycle(1'b1, 12'h052, mkdata(12'h052), 1'b1, 1'b0);
        cycle(1'b0, 12'h000, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 12'h000, 64'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
